// File: rtl/bpred_gshare_btb.sv
// bpred_gshare_btb: fetch-stage 2-bit counter predictor with tagged BTB and optional gshare indexing.
// Define BPRED_GSHARE_EN to XOR the global history into the counter index; otherwise indexing is bimodal.
module bpred_gshare_btb #(
   parameter int XLEN      = 32,
   parameter int ENTRIES   = 64,
   parameter int TAG_BITS  = 8,
   parameter int HIST_BITS = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 fetch_valid,
   input  logic [XLEN-1:0]      pc_fetch,
   output logic                 pred_taken,
   output logic [XLEN-1:0]      pred_target,
   output logic [1:0]           pred_state,
   output logic [HIST_BITS-1:0] pred_hist,
   input  logic                 update_en,
   input  logic [XLEN-1:0]      upd_pc,
   input  logic                 upd_taken,
   input  logic [XLEN-1:0]      upd_target,
   input  logic [HIST_BITS-1:0] upd_hist,
   input  logic                 upd_mispred
);
   localparam int IDX = $clog2(ENTRIES);

   logic [1:0]           ctr_q [ENTRIES];
   logic [ENTRIES-1:0]   valid_q;
   logic [TAG_BITS-1:0]  tag_q [ENTRIES];
   logic [XLEN-1:0]      tgt_q [ENTRIES];
   logic [HIST_BITS-1:0] ghr_q, ghr_d, spec_hist, rep_hist;
   logic [IDX-1:0]       f_bidx, f_cidx, u_bidx, u_cidx;
   logic [TAG_BITS-1:0]  f_tag, u_tag;
   logic [1:0]           u_ctr, u_ctr_d;
   logic                 hit;
   logic                 unused_bits;

   assign f_bidx = pc_fetch[IDX+1:2];
   assign u_bidx = upd_pc[IDX+1:2];
   assign f_tag  = pc_fetch[IDX+2 +: TAG_BITS];
   assign u_tag  = upd_pc[IDX+2 +: TAG_BITS];
   assign unused_bits = ^{pc_fetch, upd_pc, upd_hist};

`ifdef BPRED_GSHARE_EN
   assign f_cidx = f_bidx ^ IDX'(ghr_q);
   assign u_cidx = u_bidx ^ IDX'(upd_hist);
`else
   assign f_cidx = f_bidx;
   assign u_cidx = u_bidx;
`endif

   // History shifted left with the newest outcome in the LSB; a 1-bit history just holds the outcome.
   generate
      if (HIST_BITS > 1) begin : g_shift
         assign spec_hist = {ghr_q[HIST_BITS-2:0], pred_taken};
         assign rep_hist  = {upd_hist[HIST_BITS-2:0], upd_taken};
      end else begin : g_single
         assign spec_hist = pred_taken;
         assign rep_hist  = upd_taken;
      end
   endgenerate

   // Zero-latency lookup: direction needs a BTB tag hit, otherwise fall through to pc+4.
   always_comb begin
      hit         = valid_q[f_bidx] && (tag_q[f_bidx] == f_tag);
      pred_state  = ctr_q[f_cidx];
      pred_taken  = hit && pred_state[1];
      pred_target = pred_taken ? tgt_q[f_bidx] : pc_fetch + XLEN'(4);
      pred_hist   = ghr_q;
   end

   // Saturating counter step from the live table value at the resolved branch's index.
   always_comb begin
      u_ctr   = ctr_q[u_cidx];
      u_ctr_d = upd_taken ? ((u_ctr == 2'b11) ? u_ctr : u_ctr + 2'b01)
                          : ((u_ctr == 2'b00) ? u_ctr : u_ctr - 2'b01);
   end

   // Mispredict repair overrides the speculative shift; a correct resolve leaves the history alone.
   always_comb begin
      ghr_d = (update_en && upd_mispred) ? rep_hist :
              (fetch_valid && hit)       ? spec_hist : ghr_q;
   end

   // Table and history state; tags/targets are only meaningful behind valid so they are not cleared.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ghr_q   <= '0;
         valid_q <= '0;
         for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b01;
      end else begin
         ghr_q <= ghr_d;
         if (update_en) begin
            ctr_q[u_cidx] <= u_ctr_d;
            if (upd_taken) begin
               valid_q[u_bidx] <= 1'b1;
               tag_q[u_bidx]   <= u_tag;
               tgt_q[u_bidx]   <= upd_target;
            end
         end
      end
   end
endmodule
